fetch_unit: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the core's decode/execute path.
- Issues sequential word requests to an instruction memory over a req/ack handshake. The memory may take multiple cycles to respond.
- Buffers returned instructions with their PCs in a small queue and presents them to the core on a valid/ready interface.
- Supports a redirect (branch/jump target) that flushes buffered and in-flight instructions and restarts fetch at the new PC.

---
 rtl/risc_v_pkg.sv | 12 +
 rtl/fetch_queue.sv | 52 +++++
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/risc_v_pkg.sv
// rtl/risc_v_pkg.sv - shared fetch-path types and constants
package risc_v_pkg;

    typedef enum logic {
        FS_RUN,
        FS_DISCARD
    } fetch_state_t;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small synchronous FIFO of {pc, instr} with flush priority
module fetch_queue
    import risc_v_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 2,
    localparam int AW = $clog2(QUEUE_DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] push_pc_i,
    input  logic [DATA_WIDTH-1:0] push_instr_i,
    output logic [CW-1:0]         count_o,
    output logic [DATA_WIDTH-1:0] head_pc_o,
    output logic [DATA_WIDTH-1:0] head_instr_o
);

    logic [DATA_WIDTH-1:0] pc_mem_q    [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem_q [QUEUE_DEPTH];
    logic [AW-1:0]         rd_ptr_q;
    logic [AW-1:0]         wr_ptr_q;
    logic [CW-1:0]         count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i && !rst_i) begin
            pc_mem_q[wr_ptr_q]    <= push_pc_i;
            instr_mem_q[wr_ptr_q] <= push_instr_i;
        end
    end

    assign count_o      = count_q;
    assign head_pc_o    = pc_mem_q[rd_ptr_q];
    assign head_instr_o = instr_mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - sequential instruction fetch with redirect and in-flight discard
module fetch_unit
    import risc_v_pkg::*;
#(
    parameter int                  DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
    parameter int                  QUEUE_DEPTH = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Redirect,
    input  logic [DATA_WIDTH-1:0] RedirectPC,
    output logic                  MemReq,
    output logic [DATA_WIDTH-1:0] MemAddr,
    input  logic                  MemAck,
    input  logic [DATA_WIDTH-1:0] MemRData,
    output logic                  InstrValid,
    output logic [DATA_WIDTH-1:0] Instr,
    output logic [DATA_WIDTH-1:0] InstrPC,
    input  logic                  InstrReady
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] pcf_q, pcf_d;
    logic [DATA_WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic                  req_q, req_d;

    logic                  ack, pop;
    logic                  q_push, q_pop, q_flush;
    logic [CW-1:0]         q_count, count_n;
    logic [DATA_WIDTH-1:0] head_pc, head_instr;
    logic [DATA_WIDTH-1:0] redir_pc;

    assign redir_pc = RedirectPC & ~DATA_WIDTH'(3);
    assign ack      = req_q & MemAck;
    assign pop      = InstrValid & InstrReady;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= FS_RUN;
            pcf_q     <= RESET_PC;
            pend_pc_q <= '0;
            req_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pcf_q     <= pcf_d;
            pend_pc_q <= pend_pc_d;
            req_q     <= req_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pcf_d     = pcf_q;
        pend_pc_d = pend_pc_q;
        req_d     = req_q;
        q_push    = 1'b0;
        q_pop     = 1'b0;
        q_flush   = 1'b0;
        count_n   = q_count + CW'(ack) - CW'(pop);
        case (state_q)
            FS_RUN: begin
                if (Redirect) begin
                    q_flush = 1'b1;
                    // A request that has not been acked cannot be withdrawn; let it land and drop it.
                    if (req_q && !MemAck) begin
                        state_d   = FS_DISCARD;
                        pend_pc_d = redir_pc;
                    end else begin
                        pcf_d = redir_pc;
                        req_d = 1'b1;
                    end
                end else begin
                    q_push = ack;
                    q_pop  = pop;
                    if (ack) pcf_d = pcf_q + DATA_WIDTH'(INSTR_BYTES);
                    req_d = (count_n < CW'(QUEUE_DEPTH));
                end
            end
            FS_DISCARD: begin
                q_flush = 1'b1;
                if (Redirect) pend_pc_d = redir_pc;
                if (ack) begin
                    pcf_d   = Redirect ? redir_pc : pend_pc_q;
                    state_d = FS_RUN;
                    req_d   = 1'b1;
                end
            end
            default: state_d = FS_RUN;
        endcase
    end

    fetch_queue #(
        .DATA_WIDTH (DATA_WIDTH),
        .QUEUE_DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk_i       (CLK),
        .rst_i       (RST),
        .push_i      (q_push),
        .pop_i       (q_pop),
        .flush_i     (q_flush),
        .push_pc_i   (pcf_q),
        .push_instr_i(MemRData),
        .count_o     (q_count),
        .head_pc_o   (head_pc),
        .head_instr_o(head_instr)
    );

    assign MemReq     = req_q;
    assign MemAddr    = pcf_q;
    assign InstrValid = (q_count != '0);
    assign Instr      = InstrValid ? head_instr : DATA_WIDTH'(NOP_INSTR);
    assign InstrPC    = head_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck;
    logic [31:0] MemRData;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        InstrReady;

    logic        use_model;
    logic [31:0] rdata_drv;
    int          n_checks = 0;
    int          n_errors = 0;

    assign MemRData = use_model ? (32'hA0 + MemAddr) : rdata_drv;

    fetch_unit #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0000_0000),
        .QUEUE_DEPTH(2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Redirect  (Redirect),
        .RedirectPC(RedirectPC),
        .MemReq    (MemReq),
        .MemAddr   (MemAddr),
        .MemAck    (MemAck),
        .MemRData  (MemRData),
        .InstrValid(InstrValid),
        .Instr     (Instr),
        .InstrPC   (InstrPC),
        .InstrReady(InstrReady)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        check("occupancy_bound", 32'(dut.q_count <= 2), 32'd1);
    endtask

    initial begin
        RST = 1'b1; Redirect = 1'b0; RedirectPC = '0; MemAck = 1'b0;
        InstrReady = 1'b0; use_model = 1'b1; rdata_drv = '0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_memreq", 32'(MemReq), 32'd0);
            check("rst_valid", 32'(InstrValid), 32'd0);
        end
        check("rst_instr_nop", Instr, NOP);
        RST = 1'b0;
        tick();
        check("rel_memreq", 32'(MemReq), 32'd1);
        check("rel_addr", MemAddr, 32'h0);
        tick();
        check("hold_memreq", 32'(MemReq), 32'd1);
        check("hold_addr", MemAddr, 32'h0);

        // Streaming at one instruction per cycle
        MemAck = 1'b1; InstrReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stream_valid", 32'(InstrValid), 32'd1);
            check("stream_pc", InstrPC, 32'(i * 4));
            check("stream_instr", Instr, 32'hA0 + 32'(i * 4));
        end

        // Back-pressure fills the queue and stalls requests
        RST = 1'b1; MemAck = 1'b0; InstrReady = 1'b0;
        tick();
        RST = 1'b0;
        tick();
        MemAck = 1'b1;
        tick();
        check("bp_req_after1", 32'(MemReq), 32'd1);
        tick();
        check("bp_req_drop", 32'(MemReq), 32'd0);
        check("bp_addr", MemAddr, 32'h8);
        check("bp_head_pc", InstrPC, 32'h0);
        InstrReady = 1'b1;
        tick();
        check("bp_pop_pc", InstrPC, 32'h4);
        check("bp_req_again", 32'(MemReq), 32'd1);
        check("bp_addr_again", MemAddr, 32'h8);

        // Redirect while the request at 0x8 is still pending
        MemAck = 1'b0; InstrReady = 1'b0; Redirect = 1'b1; RedirectPC = 32'h100;
        tick();
        Redirect = 1'b0;
        check("rd_valid", 32'(InstrValid), 32'd0);
        check("rd_addr_held", MemAddr, 32'h8);
        check("rd_req_held", 32'(MemReq), 32'd1);
        tick();
        tick();
        check("rd_addr_held2", MemAddr, 32'h8);
        use_model = 1'b0; rdata_drv = 32'h0000_DEAD; MemAck = 1'b1; InstrReady = 1'b1;
        tick();
        check("rd_drop_valid", 32'(InstrValid), 32'd0);
        check("rd_new_addr", MemAddr, 32'h100);
        check("rd_new_req", 32'(MemReq), 32'd1);
        MemAck = 1'b0;
        tick();
        check("rd_no_dead", Instr, NOP);

        // Redirect coinciding with ack and pop
        use_model = 1'b1; MemAck = 1'b1;
        tick();
        check("sim_pre_pc", InstrPC, 32'h100);
        check("sim_pre_instr", Instr, 32'h1A0);
        Redirect = 1'b1; RedirectPC = 32'h203;
        tick();
        Redirect = 1'b0;
        check("sim_empty", 32'(InstrValid), 32'd0);
        check("sim_addr", MemAddr, 32'h200);
        tick();
        check("sim_next_pc", InstrPC, 32'h200);
        check("sim_next_instr", Instr, 32'h2A0);

        // Address wrap at the top of the space
        Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFC;
        tick();
        Redirect = 1'b0;
        check("wrap_addr", MemAddr, 32'hFFFF_FFFC);
        tick();
        check("wrap_next_addr", MemAddr, 32'h0);
        check("wrap_pc", InstrPC, 32'hFFFF_FFFC);
        check("wrap_instr", Instr, 32'h0000_009C);
        tick();
        check("wrap_addr4", MemAddr, 32'h4);

        // Reset while discarding
        MemAck = 1'b0; Redirect = 1'b1; RedirectPC = 32'h300;
        tick();
        Redirect = 1'b0;
        check("dis_addr", MemAddr, 32'h4);
        check("dis_valid", 32'(InstrValid), 32'd0);
        RST = 1'b1;
        tick();
        check("dis_rst_req", 32'(MemReq), 32'd0);
        check("dis_rst_addr", MemAddr, 32'h0);
        RST = 1'b0; MemAck = 1'b1;
        tick();
        check("post_rst_req", 32'(MemReq), 32'd1);
        check("post_rst_addr", MemAddr, 32'h0);
        tick();
        check("post_rst_valid", 32'(InstrValid), 32'd1);
        check("post_rst_pc", InstrPC, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
